display_scan: RTL and testbench

Time-multiplexed driver for the clock's multi-digit seven-segment display. Holds a frame of BCD digits in a shadow register and cycles one-hot through the digit enables at a programmable rate. For each slot it feeds the selected digit to a `segment_code` instance and presents the registered pattern on the pads. It sits between the time-keeping counters, which supply the BCD digits, and the output pins.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/segment_code.sv | 30 +++
 rtl/display_scan.sv | 112 +++++++++++
 tb/tb_display_scan.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock display path: BCD digit type,
// seven-segment patterns (bit0 = a ... bit6 = g, 1 = lit) and default digit count.
package clock_pkg;

    localparam int NUM_DIGITS_DEF = 6;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/segment_code.sv
// BCD to seven-segment decoder, purely combinational.
// Non-decimal codes and blanked digits produce an all-off pattern.
module segment_code
    import clock_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed seven-segment scanner with pending/active frame shadow registers.
// New frames are only swapped in at the frame boundary so the display never tears.
module display_scan
    import clock_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    bcd_t [NUM_DIGITS-1:0] act_digits;
    bcd_t [NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0] act_dp;
    logic [NUM_DIGITS-1:0] act_blank;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] pend_blank;
    logic                  pend;

    logic       wrap;
    logic       drive;
    bcd_t       cur_digit;
    logic       cur_dp;
    logic       cur_blank;
    logic [6:0] seg_dec;

    assign wrap      = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign drive     = (cnt >= BLANK_END);
    assign cur_digit = act_digits[idx];
    assign cur_dp    = act_dp[idx];
    assign cur_blank = act_blank[idx];

    segment_code u_segment_code (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A load coinciding with the boundary bypasses the pending copy entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_digits  <= '0;
            act_dp      <= '0;
            act_blank   <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '0;
            pend        <= 1'b0;
        end else if (load && wrap) begin
            act_digits <= digits_in;
            act_dp     <= dp_in;
            act_blank  <= blank_in;
            pend       <= 1'b0;
        end else if (load) begin
            pend_digits <= digits_in;
            pend_dp     <= dp_in;
            pend_blank  <= blank_in;
            pend        <= 1'b1;
        end else if (wrap && pend) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            pend       <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out     <= SEG_OFF;
            dp_out      <= 1'b0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= drive ? seg_dec : SEG_OFF;
            dp_out      <= drive & cur_dp & ~cur_blank;
            digit_sel   <= drive ? (NUM_DIGITS'(1) << idx) : '0;
            frame_start <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: cycle-accurate reference model plus frame-capture vectors.
module tb_display_scan;

    localparam int ND = 6;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FP = ND * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] digits_in;
    logic [5:0]  dp_in;
    logic [5:0]  blank_in;
    logic        load;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [5:0]  digit_sel;
    logic        frame_start;

    display_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .load        (load),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: cycles since reset and the two frame copies
    int         m_t;
    logic [3:0] m_dig [ND];
    logic [5:0] m_dp, m_bl;
    logic [3:0] p_dig [ND];
    logic [5:0] p_dp, p_bl;
    bit         m_pend;

    logic [6:0] e_seg;
    logic       e_dp;
    logic [5:0] e_sel;
    logic       e_fs;
    bit         e_first;

    typedef struct {
        logic [23:0] dig;
        logic [5:0]  dp;
        logic [5:0]  bl;
        logic [41:0] segs;
        logic [5:0]  edp;
    } vec_t;

    vec_t vt [5];

    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        int  cnt, idx;
        bit  drv, wrap;
        if (rst) begin
            m_t = 0;
            for (int i = 0; i < ND; i++) begin
                m_dig[i] = 4'd0;
                p_dig[i] = 4'd0;
            end
            m_dp = '0; m_bl = '0; p_dp = '0; p_bl = '0; m_pend = 0;
            e_seg = '0; e_dp = 0; e_sel = '0; e_fs = 0; e_first = 0;
        end else begin
            cnt     = m_t % SD;
            idx     = (m_t / SD) % ND;
            drv     = (cnt >= BC);
            wrap    = ((m_t % FP) == FP - 1);
            e_fs    = ((m_t % FP) == 0);
            e_first = (cnt == 0);
            e_sel   = drv ? 6'(1 << idx) : 6'd0;
            e_seg   = (drv && !m_bl[idx]) ? pat(m_dig[idx]) : 7'h00;
            e_dp    = drv && m_dp[idx] && !m_bl[idx];
            if (load && wrap) begin
                for (int i = 0; i < ND; i++) m_dig[i] = digits_in[4*i +: 4];
                m_dp = dp_in; m_bl = blank_in; m_pend = 0;
            end else if (load) begin
                for (int i = 0; i < ND; i++) p_dig[i] = digits_in[4*i +: 4];
                p_dp = dp_in; p_bl = blank_in; m_pend = 1;
            end else if (wrap && m_pend) begin
                for (int i = 0; i < ND; i++) m_dig[i] = p_dig[i];
                m_dp = p_dp; m_bl = p_bl; m_pend = 0;
            end
            m_t++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("seg_out", 64'(seg_out), 64'(e_seg));
        check("dp_out", 64'(dp_out), 64'(e_dp));
        check("digit_sel", 64'(digit_sel), 64'(e_sel));
        check("frame_start", 64'(frame_start), 64'(e_fs));
        check("sel_onehot0", 64'($countones(digit_sel) <= 1), 64'(1));
        if (e_first)
            check("slot_head_dark", 64'({digit_sel, seg_out, dp_out}), 64'(0));
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl);
        digits_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic goto_phase(input int ph);
        for (int i = 0; i < 2 * FP && (m_t % FP) != ph; i++) step();
        check("goto_phase", 64'(m_t % FP), 64'(ph));
    endtask

    // waits for the next frame_start, then records what each digit slot displayed
    task automatic capture_frame(output logic [41:0] segs, output logic [5:0] dps);
        bit ok = 0;
        segs = 'x;
        dps  = 'x;
        for (int i = 0; i < 3 * FP && !ok; i++) begin
            step();
            if (frame_start) ok = 1;
        end
        check("frame_found", 64'(ok), 64'(1));
        for (int i = 0; i < FP - 1; i++) begin
            step();
            for (int j = 0; j < ND; j++) begin
                if (digit_sel[j]) begin
                    segs[j*7 +: 7] = seg_out;
                    dps[j]         = dp_out;
                end
            end
        end
    endtask

    task automatic compare_frame(input string tag, input logic [41:0] segs, input logic [5:0] dps,
                                 input logic [41:0] es, input logic [5:0] ed);
        for (int j = 0; j < ND; j++) begin
            check($sformatf("%s_seg%0d", tag, j), 64'(segs[j*7 +: 7]), 64'(es[j*7 +: 7]));
            check($sformatf("%s_dp%0d", tag, j), 64'(dps[j]), 64'(ed[j]));
        end
    endtask

    initial begin
        logic [41:0] cs;
        logic [5:0]  cd;
        int          fs_cnt;

        vt[0] = '{24'h954321, 6'b000000, 6'b000000,
                  {7'h6F, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06}, 6'b000000};
        vt[1] = '{24'h84B720, 6'b000100, 6'b100000,
                  {7'h00, 7'h66, 7'h00, 7'h07, 7'h5B, 7'h3F}, 6'b000100};
        vt[2] = '{24'h000000, 6'b111111, 6'b000000,
                  {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 6'b111111};
        vt[3] = '{24'hFEDCBA, 6'b101010, 6'b000000,
                  {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}, 6'b101010};
        vt[4] = '{24'h876543, 6'b111111, 6'b010101,
                  {7'h7F, 7'h00, 7'h7D, 7'h00, 7'h66, 7'h00}, 6'b101010};

        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
        step();
        step();
        check("reset_outputs", 64'({seg_out, dp_out, digit_sel, frame_start}), 64'(0));
        rst = 1'b0;

        // reset with no load: blank first cycle, then digit 0 showing "0"
        step();
        check("t1_first_fs", 64'({frame_start, digit_sel}), 64'({1'b1, 6'h00}));
        step();
        check("t1_first_drive", 64'({digit_sel, seg_out}), 64'({6'h01, 7'h3F}));
        fs_cnt = 0;
        for (int i = 0; i < 2 * FP; i++) begin
            step();
            if (frame_start) fs_cnt++;
        end
        check("t1_fs_per_frame", 64'(fs_cnt), 64'(2));

        // mid-frame loads show up on the following frame
        for (int v = 0; v < 5; v++) begin
            goto_phase(2 + $urandom_range(0, 20));
            do_load(vt[v].dig, vt[v].dp, vt[v].bl);
            capture_frame(cs, cd);
            compare_frame($sformatf("vec%0d", v), cs, cd, vt[v].segs, vt[v].edp);
        end

        // load exactly on the wrap cycle
        goto_phase(FP - 1);
        do_load(vt[2].dig, vt[2].dp, vt[2].bl);
        capture_frame(cs, cd);
        compare_frame("wrap_load", cs, cd, vt[2].segs, vt[2].edp);

        // back-to-back loads before a boundary: last one wins
        do_load(vt[3].dig, vt[3].dp, vt[3].bl);
        do_load(vt[4].dig, vt[4].dp, vt[4].bl);
        capture_frame(cs, cd);
        compare_frame("last_wins", cs, cd, vt[4].segs, vt[4].edp);

        // anti-ghosting sweep over three frames
        for (int i = 0; i < 3 * FP; i++) step();

        // reset at idx 3 with a load pending
        goto_phase(2);
        do_load(vt[2].dig, vt[2].dp, vt[2].bl);
        goto_phase(3 * SD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_reset_dark", 64'({seg_out, dp_out, digit_sel, frame_start}), 64'(0));
        step();
        check("t6_restart_fs", 64'({frame_start, digit_sel}), 64'({1'b1, 6'h00}));
        step();
        check("t6_restart_drive", 64'({digit_sel, seg_out, dp_out}), 64'({6'h01, 7'h3F, 1'b0}));
        capture_frame(cs, cd);
        compare_frame("t6_discard", cs, cd,
                      {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 6'b000000);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            digits_in = 24'($urandom);
            dp_in     = 6'($urandom);
            blank_in  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            load      = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        load = 1'b0;
        rst  = 1'b0;
        for (int i = 0; i < 2 * FP; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
